// File: rtl/sprite_blitter_if.sv
// Bus bundle between the sprite blitter, the registered sprite ROM read
// mux and the LT24 frame-buffer write port.
interface sprite_blitter_if;
  logic [3:0]  ROM;
  logic [15:0] ROMAddr;
  logic [15:0] ReadROMOut;
  logic        fbWrite;
  logic [16:0] fbAddr;
  logic [15:0] fbData;
  logic        fbReady;

  modport master (
    output ROM, ROMAddr, fbWrite, fbAddr, fbData,
    input  ReadROMOut, fbReady
  );

  modport slave (
    input  ROM, ROMAddr, fbWrite, fbAddr, fbData,
    output ReadROMOut, fbReady
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks every pixel of one sprite ROM frame, waits out the
// ROM mux read latency, and writes each opaque on-screen pixel into the
// frame buffer through a valid/ready handshake.
module sprite_blitter #(
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 16,
  parameter int          FB_WIDTH    = 240,
  parameter int          FB_HEIGHT   = 320,
  parameter int          ROM_LATENCY = 2,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] frame,
  input  logic [7:0] xOrigin,
  input  logic [8:0] yOrigin,
  output logic       busy,
  output logic       done,
  sprite_blitter_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PX_W   = $clog2(SPRITE_W + 1);
  localparam int PY_W   = $clog2(SPRITE_H + 1);
  localparam int WAIT_W = $clog2(ROM_LATENCY + 1) + 1;

  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(SPRITE_W - 1);
  localparam logic [PY_W-1:0]   PY_LAST   = PY_W'(SPRITE_H - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LATENCY);

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [PX_W-1:0]   r_px;
  logic [PY_W-1:0]   r_py;
  logic [7:0]        r_x;
  logic [8:0]        r_y;
  logic [3:0]        r_rom;
  logic [15:0]       r_romAddr;
  logic              r_fbWrite;
  logic [16:0]       r_fbAddr;
  logic [15:0]       r_fbData;
  logic              r_busy;
  logic              r_done;

  logic [8:0]      w_xSum;
  logic [9:0]      w_ySum;
  logic            w_onScreen;
  logic            w_skip;
  logic            w_sampleNow;
  logic            w_advance;
  logic            w_lastPx;
  logic            w_final;
  logic [PX_W-1:0] w_pxNext;
  logic [PY_W-1:0] w_pyNext;
  logic [15:0]     w_romAddrNext;
  logic [16:0]     w_fbAddr;

  // Screen position of the current pixel, widened so the clip test never wraps.
  assign w_xSum     = {1'b0, r_x} + 9'(r_px);
  assign w_ySum     = {1'b0, r_y} + 10'(r_py);
  assign w_onScreen = (w_xSum < 9'(FB_WIDTH)) && (w_ySum < 10'(FB_HEIGHT));
  assign w_fbAddr   = 17'(w_ySum) * 17'(FB_WIDTH) + 17'(w_xSum);

  // The pixel is sampled on the last fetch cycle; skipped pixels advance at once.
  assign w_sampleNow = (r_state == S_FETCH) && (r_wait == WAIT_LAST);
  assign w_skip      = (bus.ReadROMOut == TRANSPARENT) || !w_onScreen;
  assign w_advance   = (w_sampleNow && w_skip) || ((r_state == S_WRITE) && bus.fbReady);

  // Raster-order step to the next sprite pixel.
  assign w_lastPx      = (r_px == PX_LAST);
  assign w_final       = w_lastPx && (r_py == PY_LAST);
  assign w_pxNext      = w_lastPx ? '0 : r_px + 1'b1;
  assign w_pyNext      = w_lastPx ? r_py + 1'b1 : r_py;
  assign w_romAddrNext = 16'(w_pyNext) * 16'(SPRITE_W) + 16'(w_pxNext);

  assign bus.ROM     = r_rom;
  assign bus.ROMAddr = r_romAddr;
  assign bus.fbWrite = r_fbWrite;
  assign bus.fbAddr  = r_fbAddr;
  assign bus.fbData  = r_fbData;
  assign busy        = r_busy;
  assign done        = r_done;

  // Draw sequencer: accept start, fetch each pixel, hand opaque ones to the frame buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_rom     <= '0;
      r_romAddr <= '0;
      r_fbWrite <= 1'b0;
      r_fbAddr  <= '0;
      r_fbData  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rom     <= frame;
            r_x       <= xOrigin;
            r_y       <= yOrigin;
            r_px      <= '0;
            r_py      <= '0;
            r_romAddr <= '0;
            r_wait    <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_sampleNow) begin
            if (!w_skip) begin
              r_fbData  <= bus.ReadROMOut;
              r_fbAddr  <= w_fbAddr;
              r_fbWrite <= 1'b1;
              r_state   <= S_WRITE;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.fbReady) begin
            r_fbWrite <= 1'b0;
          end
        end
        default: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      if (w_advance) begin
        r_wait <= '0;
        r_px   <= w_pxNext;
        if (w_final) begin
          r_state <= S_DONE;
        end else begin
          r_py      <= w_pyNext;
          r_romAddr <= w_romAddrNext;
          r_state   <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a two-stage registered ROM model,
// a frame-buffer acceptor with selectable ready pattern, and a reference
// model that lists the expected writes straight from the drawing rules.
module tb_sprite_blitter;

  localparam logic [15:0] TRANSP = 16'hF81F;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] frame;
  logic [7:0] xOrigin;
  logic [8:0] yOrigin;
  logic       busy;
  logic       done;

  sprite_blitter_if bus();

  sprite_blitter dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .frame   (frame),
    .xOrigin (xOrigin),
    .yOrigin (yOrigin),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int startCyc = 0;
  int readyMode = 0;

  logic [15:0] romMem [0:15][0:255];
  logic [15:0] romQ;

  logic [32:0] wrQ[$];
  logic [32:0] expQ[$];
  int          stabBad = 0;
  int          writeHighSeen = 0;
  logic        pendValid = 1'b0;
  logic [16:0] pendAddr;
  logic [15:0] pendData;

  // Free-running clock and edge counter used for latency measurements.
  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Sprite ROM followed by the mux output register: two edges of read latency.
  always @(posedge clock) begin
    romQ           <= romMem[bus.ROM][bus.ROMAddr[7:0]];
    bus.ReadROMOut <= romQ;
  end

  // Frame-buffer ready pattern: always ready, one cycle in four, or never.
  always @(posedge clock) begin
    #1;
    case (readyMode)
      0:       bus.fbReady = 1'b1;
      1:       bus.fbReady = (cycle % 4 == 0);
      default: bus.fbReady = 1'b0;
    endcase
  end

  // Records completed handshakes and watches that a stalled write is held steady.
  always @(negedge clock) begin
    if (reset) begin
      pendValid = 1'b0;
    end else begin
      if (pendValid && (bus.fbWrite !== 1'b1 || bus.fbAddr !== pendAddr || bus.fbData !== pendData))
        stabBad++;
      if (bus.fbWrite === 1'b1) writeHighSeen++;
      if (bus.fbWrite === 1'b1 && bus.fbReady === 1'b1) wrQ.push_back({bus.fbAddr, bus.fbData});
      pendValid = (bus.fbWrite === 1'b1) && (bus.fbReady !== 1'b1);
      pendAddr  = bus.fbAddr;
      pendData  = bus.fbData;
    end
  end

  task automatic fillFrame(input int fr, input bit evenTransparent);
    logic [15:0] v;
    for (int a = 0; a < 256; a++) begin
      v = 16'($urandom);
      if (v == TRANSP) v = 16'h0000;
      if (evenTransparent && ((a % 16) % 2 == 0)) v = TRANSP;
      romMem[fr][a] = v;
    end
  endtask

  // Reference: every sprite pixel in raster order, kept if opaque and on screen;
  // with ready held high an opaque pixel costs 4 cycles, a skipped one 3, plus 1 for done.
  task automatic buildModel(input int fr, input int x, input int y, output int expOffs);
    logic [15:0] pix;
    expQ.delete();
    expOffs = 1;
    for (int py = 0; py < 16; py++) begin
      for (int px = 0; px < 16; px++) begin
        pix = romMem[fr][py * 16 + px];
        if (pix != TRANSP && (x + px) < 240 && (y + py) < 320) begin
          expQ.push_back({17'((y + py) * 240 + x + px), pix});
          expOffs += 4;
        end else begin
          expOffs += 3;
        end
      end
    end
  endtask

  function automatic int countDiff();
    int n;
    n = 0;
    for (int i = 0; i < wrQ.size() && i < expQ.size(); i++)
      if (wrQ[i] !== expQ[i]) n++;
    if (wrQ.size() > expQ.size()) n += wrQ.size() - expQ.size();
    if (expQ.size() > wrQ.size()) n += expQ.size() - wrQ.size();
    return n;
  endfunction

  task automatic doStart(input int fr, input int x, input int y);
    frame   = 4'(fr);
    xOrigin = 8'(x);
    yOrigin = 9'(y);
    start   = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    startCyc = cycle;
  endtask

  task automatic waitDone(input int limit, output int offs, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    offs = cycle - startCyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    frame = '0;
    xOrigin = '0;
    yOrigin = '0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (bus.fbWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_fbWrite: got %b expected 0", bus.fbWrite); end
    checks++; if (bus.ROM !== 4'd0 || bus.ROMAddr !== 16'd0) begin errors++; $display("[TB] FAIL reset_rom: got ROM=%0d ROMAddr=%0d expected 0/0", bus.ROM, bus.ROMAddr); end
    checks++; if (bus.fbAddr !== 17'd0 || bus.fbData !== 16'd0) begin errors++; $display("[TB] FAIL reset_fb: got fbAddr=%0d fbData=%h expected 0/0", bus.fbAddr, bus.fbData); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_opaque_origin();
    int expOffs, offs;
    bit ok;
    fillFrame(0, 1'b0);
    buildModel(0, 0, 0, expOffs);
    wrQ.delete();
    doStart(0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL opaque_busy: got %b expected 1", busy); end
    waitDone(3000, offs, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL opaque_timeout: got no done expected done"); end
    checks++; if (offs != 1025) begin errors++; $display("[TB] FAIL opaque_latency: got %0d expected 1025", offs); end
    checks++; if (wrQ.size() != 256) begin errors++; $display("[TB] FAIL opaque_count: got %0d expected 256", wrQ.size()); end
    checks++; if (countDiff() != 0) begin errors++; $display("[TB] FAIL opaque_writes: got %0d bad entries expected 0", countDiff()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL opaque_busy_at_done: got %b expected 0", busy); end
    @(negedge clock);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL opaque_done_pulse: got done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_clip_corner();
    int expOffs, offs;
    bit ok;
    fillFrame(1, 1'b0);
    buildModel(1, 232, 312, expOffs);
    wrQ.delete();
    doStart(1, 232, 312);
    waitDone(3000, offs, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL clip_timeout: got no done expected done"); end
    checks++; if (wrQ.size() != 64) begin errors++; $display("[TB] FAIL clip_count: got %0d expected 64", wrQ.size()); end
    checks++; if (wrQ.size() == 0 || wrQ[0][32:16] !== 17'd75112) begin errors++; $display("[TB] FAIL clip_first: got %0d expected 75112", wrQ.size() ? wrQ[0][32:16] : 17'd0); end
    checks++; if (wrQ.size() == 0 || wrQ[$][32:16] !== 17'd76799) begin errors++; $display("[TB] FAIL clip_last: got %0d expected 76799", wrQ.size() ? wrQ[$][32:16] : 17'd0); end
    checks++; if (countDiff() != 0) begin errors++; $display("[TB] FAIL clip_writes: got %0d bad entries expected 0", countDiff()); end
    checks++; if (offs != expOffs) begin errors++; $display("[TB] FAIL clip_latency: got %0d expected %0d", offs, expOffs); end
  endtask

  task automatic test_transparent();
    int expOffs, offs, x, y, nTr;
    bit ok;
    x = $urandom_range(0, 224);
    y = $urandom_range(0, 304);
    fillFrame(3, 1'b1);
    buildModel(3, x, y, expOffs);
    wrQ.delete();
    doStart(3, x, y);
    waitDone(3000, offs, ok);
    nTr = 0;
    foreach (wrQ[i]) if (wrQ[i][15:0] == TRANSP) nTr++;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL transp_timeout: got no done expected done"); end
    checks++; if (wrQ.size() != 128) begin errors++; $display("[TB] FAIL transp_count: got %0d expected 128", wrQ.size()); end
    checks++; if (nTr != 0) begin errors++; $display("[TB] FAIL transp_colour_written: got %0d expected 0", nTr); end
    checks++; if (offs != 897) begin errors++; $display("[TB] FAIL transp_latency: got %0d expected 897", offs); end
    checks++; if (countDiff() != 0) begin errors++; $display("[TB] FAIL transp_writes: got %0d bad entries expected 0", countDiff()); end
  endtask

  task automatic test_offscreen();
    int expOffs, offs, y;
    bit ok;
    y = $urandom_range(0, 300);
    fillFrame(6, 1'b0);
    buildModel(6, 245, y, expOffs);
    wrQ.delete();
    doStart(6, 245, y);
    waitDone(3000, offs, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL offscreen_timeout: got no done expected done"); end
    checks++; if (wrQ.size() != 0) begin errors++; $display("[TB] FAIL offscreen_count: got %0d expected 0", wrQ.size()); end
    checks++; if (offs != 769) begin errors++; $display("[TB] FAIL offscreen_latency: got %0d expected 769", offs); end
  endtask

  task automatic test_ready_toggle();
    int expOffs, offs, x, y;
    bit ok;
    x = $urandom_range(0, 224);
    y = $urandom_range(0, 304);
    fillFrame(4, 1'b0);
    buildModel(4, x, y, expOffs);
    wrQ.delete();
    stabBad = 0;
    readyMode = 1;
    doStart(4, x, y);
    waitDone(8000, offs, ok);
    readyMode = 0;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL toggle_timeout: got no done expected done"); end
    checks++; if (wrQ.size() != 256) begin errors++; $display("[TB] FAIL toggle_count: got %0d expected 256", wrQ.size()); end
    checks++; if (countDiff() != 0) begin errors++; $display("[TB] FAIL toggle_writes: got %0d bad entries expected 0", countDiff()); end
    checks++; if (stabBad != 0) begin errors++; $display("[TB] FAIL toggle_hold: got %0d unstable stalls expected 0", stabBad); end
  endtask

  task automatic test_back_to_back();
    int expOffs, offs;
    bit ok;
    fillFrame(5, 1'b0);
    fillFrame(2, 1'b0);
    buildModel(5, 10, 20, expOffs);
    wrQ.delete();
    doStart(5, 10, 20);
    repeat (100) @(negedge clock);
    frame = 4'd2;
    xOrigin = 8'd100;
    yOrigin = 9'd200;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++; if (bus.ROM !== 4'd5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL ignored_start: got ROM=%0d busy=%b expected 5/1", bus.ROM, busy); end
    waitDone(3000, offs, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL first_draw_timeout: got no done expected done"); end
    checks++; if (countDiff() != 0) begin errors++; $display("[TB] FAIL first_draw_writes: got %0d bad entries expected 0", countDiff()); end
    buildModel(2, 100, 200, expOffs);
    wrQ.delete();
    doStart(2, 100, 200);
    checks++; if (bus.ROM !== 4'd2 || busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_accept: got ROM=%0d busy=%b expected 2/1", bus.ROM, busy); end
    waitDone(3000, offs, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL second_draw_timeout: got no done expected done"); end
    checks++; if (offs != expOffs) begin errors++; $display("[TB] FAIL second_draw_latency: got %0d expected %0d", offs, expOffs); end
    checks++; if (countDiff() != 0) begin errors++; $display("[TB] FAIL second_draw_writes: got %0d bad entries expected 0", countDiff()); end
  endtask

  task automatic test_reset_mid_write();
    bit found;
    readyMode = 2;
    fillFrame(7, 1'b0);
    wrQ.delete();
    doStart(7, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.fbWrite === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL midwrite_reach: got no fbWrite expected fbWrite"); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.fbWrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midwrite_async: got fbWrite=%b busy=%b expected 0/0", bus.fbWrite, busy); end
    @(negedge clock);
    reset = 1'b0;
    readyMode = 0;
    writeHighSeen = 0;
    wrQ.delete();
    repeat (40) @(negedge clock);
    checks++; if (writeHighSeen != 0 || wrQ.size() != 0) begin errors++; $display("[TB] FAIL midwrite_no_writes: got %0d write cycles expected 0", writeHighSeen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midwrite_busy: got %b expected 0", busy); end
  endtask

  initial begin
    bus.fbReady = 1'b0;
    test_reset();
    test_opaque_origin();
    test_clip_corner();
    test_transparent();
    test_offscreen();
    test_ready_toggle();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
